multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 35 +++
 rtl/aludec.sv | 31 +++
 rtl/multicycle_controller.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
package multicycle_controller_pkg;

   typedef enum logic [3:0] {
      StFetch,
      StDecode,
      StMemAdr,
      StMemRead,
      StMemWb,
      StMemWrite,
      StExecuteR,
      StExecuteI,
      StAluWb,
      StBeq,
      StJal
   } state_e;

   localparam logic [6:0] OpLw   = 7'b0000011;
   localparam logic [6:0] OpSw   = 7'b0100011;
   localparam logic [6:0] OpR    = 7'b0110011;
   localparam logic [6:0] OpIAlu = 7'b0010011;
   localparam logic [6:0] OpBeq  = 7'b1100011;
   localparam logic [6:0] OpJal  = 7'b1101111;

   localparam logic [1:0] AluOpAdd   = 2'b00;
   localparam logic [1:0] AluOpSub   = 2'b01;
   localparam logic [1:0] AluOpFunct = 2'b10;

   localparam logic [2:0] AluCtlAdd = 3'b000;
   localparam logic [2:0] AluCtlSub = 3'b001;
   localparam logic [2:0] AluCtlAnd = 3'b010;
   localparam logic [2:0] AluCtlOr  = 3'b011;
   localparam logic [2:0] AluCtlSlt = 3'b101;

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the FSM's aluop plus instruction fields to an ALU operation.
module aludec
   import multicycle_controller_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [2:0] funct3,
   input  logic       op5,
   input  logic       funct7b5,
   output logic [2:0] alucontrol
);

   // Subtract only for R-type with funct7b5 set; I-type addi never subtracts.
   always_comb begin
      alucontrol = AluCtlAdd;
      case (aluop)
         AluOpAdd: alucontrol = AluCtlAdd;
         AluOpSub: alucontrol = AluCtlSub;
         AluOpFunct: begin
            case (funct3)
               3'b000:  alucontrol = (op5 && funct7b5) ? AluCtlSub : AluCtlAdd;
               3'b010:  alucontrol = AluCtlSlt;
               3'b110:  alucontrol = AluCtlOr;
               3'b111:  alucontrol = AluCtlAnd;
               default: alucontrol = AluCtlAdd;
            endcase
         end
         default: alucontrol = AluCtlAdd;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RISC-V datapath (lw, sw, R, I-ALU, beq, jal).
module multicycle_controller
   import multicycle_controller_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic [1:0] immsrc,
   output logic [1:0] alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] resultsrc,
   output logic       adrsrc,
   output logic [2:0] alucontrol,
   output logic       irwrite,
   output logic       pcwrite,
   output logic       regwrite,
   output logic       memwrite,
   output logic       illegal
);

   state_e     state_q, state_d;
   state_e     cur_state;
   logic [1:0] aluop;
   logic       irwrite_raw, regwrite_raw, memwrite_raw;
   logic       pcupdate, branch;
   logic       op_legal;

   assign op_legal = (op == OpLw) || (op == OpSw) || (op == OpR) ||
                     (op == OpIAlu) || (op == OpBeq) || (op == OpJal);

   // While reset is held the outputs decode as FETCH, whatever the register holds.
   assign cur_state = reset ? StFetch : state_q;

   // State register; reset abandons any partial instruction.
   always_ff @(posedge clk) begin
      if (reset) state_q <= StFetch;
      else       state_q <= state_d;
   end

   // Next-state selection.
   always_comb begin
      state_d = StFetch;
      case (state_q)
         StFetch:  state_d = StDecode;
         StDecode: begin
            if (op == OpLw || op == OpSw) state_d = StMemAdr;
            else if (op == OpR)           state_d = StExecuteR;
            else if (op == OpIAlu)        state_d = StExecuteI;
            else if (op == OpBeq)         state_d = StBeq;
            else if (op == OpJal)         state_d = StJal;
            else                          state_d = StFetch;
         end
         StMemAdr:   state_d = (op == OpLw) ? StMemRead : StMemWrite;
         StMemRead:  state_d = StMemWb;
         StMemWb:    state_d = StFetch;
         StMemWrite: state_d = StFetch;
         StExecuteR: state_d = StAluWb;
         StExecuteI: state_d = StAluWb;
         StAluWb:    state_d = StFetch;
         StJal:      state_d = StAluWb;
         StBeq:      state_d = StFetch;
         default:    state_d = StFetch;
      endcase
   end

   // Per-state datapath controls; anything not set stays 0.
   always_comb begin
      alusrca      = 2'b00;
      alusrcb      = 2'b00;
      resultsrc    = 2'b00;
      adrsrc       = 1'b0;
      aluop        = AluOpAdd;
      irwrite_raw  = 1'b0;
      regwrite_raw = 1'b0;
      memwrite_raw = 1'b0;
      pcupdate     = 1'b0;
      branch       = 1'b0;
      case (cur_state)
         StFetch: begin
            irwrite_raw = 1'b1;
            alusrcb     = 2'b10;
            resultsrc   = 2'b10;
            pcupdate    = 1'b1;
         end
         StDecode: begin
            alusrca = 2'b01;
            alusrcb = 2'b01;
         end
         StMemAdr: begin
            alusrca = 2'b10;
            alusrcb = 2'b01;
         end
         StMemRead: adrsrc = 1'b1;
         StMemWb: begin
            resultsrc    = 2'b01;
            regwrite_raw = 1'b1;
         end
         StMemWrite: begin
            adrsrc       = 1'b1;
            memwrite_raw = 1'b1;
         end
         StExecuteR: begin
            alusrca = 2'b10;
            aluop   = AluOpFunct;
         end
         StExecuteI: begin
            alusrca = 2'b10;
            alusrcb = 2'b01;
            aluop   = AluOpFunct;
         end
         StAluWb: regwrite_raw = 1'b1;
         StJal: begin
            alusrca  = 2'b01;
            alusrcb  = 2'b10;
            pcupdate = 1'b1;
         end
         StBeq: begin
            alusrca = 2'b10;
            aluop   = AluOpSub;
            branch  = 1'b1;
         end
         default: ;
      endcase
   end

   // Immediate format depends only on the opcode.
   always_comb begin
      immsrc = 2'b00;
      case (op)
         OpSw:    immsrc = 2'b01;
         OpBeq:   immsrc = 2'b10;
         OpJal:   immsrc = 2'b11;
         default: immsrc = 2'b00;
      endcase
   end

   assign irwrite  = irwrite_raw & ~reset;
   assign regwrite = regwrite_raw & ~reset;
   assign memwrite = memwrite_raw & ~reset;
   assign pcwrite  = (pcupdate | (branch & zero)) & ~reset;
   assign illegal  = (cur_state == StDecode) & ~op_legal & ~reset;

   aludec u_aludec (
      .aluop      (aluop),
      .funct3     (funct3),
      .op5        (op[5]),
      .funct7b5   (funct7b5),
      .alucontrol (alucontrol)
   );

endmodule
